// File: rtl/neural_acq_multich_frontend_pkg.sv
// Shared types and helpers for the multi-channel neural acquisition front end.
// Default widths live here so the FIFO entry type can be reused elsewhere.
package neural_acq_pkg;

    localparam int ACQ_DATA_WIDTH     = 16;
    localparam int ACQ_CH_ID_WIDTH    = 4;
    localparam int ACQ_MAX_DECIM_LOG2 = 3;
    localparam int ACQ_FIFO_DEPTH     = 8;
    localparam int ACQ_CNT_WIDTH      = 16;

    localparam int ACC_WIDTH = ACQ_DATA_WIDTH + ACQ_MAX_DECIM_LOG2;
    localparam int LVL_WIDTH = $clog2(ACQ_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ACQ_CH_ID_WIDTH-1:0] channel;
        logic [ACQ_DATA_WIDTH-1:0]  data;
    } acq_sample_t;

    function automatic logic [ACQ_CNT_WIDTH-1:0] sat_inc(
        input logic [ACQ_CNT_WIDTH-1:0] cnt
    );
        return (&cnt) ? cnt : cnt + ACQ_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/neural_acq_multich_frontend_if.sv
// Ready/valid output bus carrying averaged samples to the downstream DSP.
interface neural_acq_out_if;
    import neural_acq_pkg::*;

    logic [ACQ_DATA_WIDTH-1:0]  out_data;
    logic [ACQ_CH_ID_WIDTH-1:0] out_channel;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output out_data, out_channel, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_channel, out_valid,
        output out_ready
    );

endinterface

// File: rtl/neural_acq_multich_frontend_fifo.sv
// First-word-fall-through synchronous FIFO of acq_sample_t entries.
module acq_sync_fifo
    import neural_acq_pkg::*;
#(
    parameter int DEPTH = ACQ_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  acq_sample_t                din,
    input  logic                       pop,
    output acq_sample_t                dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    acq_sample_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level + LW'(do_wr) - LW'(do_rd);
        end
    end

endmodule

// File: rtl/neural_acq_multich_frontend.sv
// Multi-channel ADC front end: tag/mask qualification, per-channel boxcar
// decimation, output FIFO and drop/bad-channel statistics.
module neural_acq_multich_frontend
    import neural_acq_pkg::*;
#(
    parameter int DATA_WIDTH     = ACQ_DATA_WIDTH,
    parameter int CH_ID_WIDTH    = ACQ_CH_ID_WIDTH,
    parameter int NUM_CH         = 16,
    parameter int MAX_DECIM_LOG2 = ACQ_MAX_DECIM_LOG2,
    parameter int FIFO_DEPTH     = ACQ_FIFO_DEPTH,
    parameter int CNT_WIDTH      = ACQ_CNT_WIDTH
) (
    input  logic                                sensor_clk,
    input  logic                                sensor_rst,
    input  logic [DATA_WIDTH-1:0]               adc_data_in,
    input  logic [CH_ID_WIDTH-1:0]              adc_channel_in,
    input  logic                                adc_valid_in,
    input  logic [NUM_CH-1:0]                   ch_enable_mask,
    input  logic [$clog2(MAX_DECIM_LOG2+1)-1:0] cfg_decim_log2,
    input  logic                                cfg_clr_stats,
    neural_acq_out_if.master                    out_if,
    output logic [CNT_WIDTH-1:0]                ovf_count,
    output logic [CNT_WIDTH-1:0]                badch_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

    localparam int AW = DATA_WIDTH + MAX_DECIM_LOG2;
    localparam int CW = MAX_DECIM_LOG2;
    localparam int DW = $clog2(MAX_DECIM_LOG2 + 1);

    logic                   tag_ok;
    logic [CH_ID_WIDTH-1:0] ch_idx;
    logic                   accept;
    logic                   mask_drop;
    logic                   bad_evt;
    logic [DW-1:0]          dec_in;

    assign tag_ok    = {1'b0, adc_channel_in} < (CH_ID_WIDTH+1)'(NUM_CH);
    assign ch_idx    = tag_ok ? adc_channel_in : '0;
    assign accept    = adc_valid_in && tag_ok && ch_enable_mask[ch_idx];
    assign mask_drop = adc_valid_in && tag_ok && !ch_enable_mask[ch_idx];
    assign bad_evt   = adc_valid_in && !tag_ok;
    assign dec_in    = (cfg_decim_log2 > DW'(MAX_DECIM_LOG2))
                     ? DW'(MAX_DECIM_LOG2) : cfg_decim_log2;

    logic                   in_vld_q;
    logic                   mclr_q;
    logic                   chg_q;
    logic [CH_ID_WIDTH-1:0] in_ch_q;
    logic [DATA_WIDTH-1:0]  in_data_q;
    logic [DW-1:0]          dec_q;

    // Qualified input register; the decimation change flag travels with it.
    always_ff @(posedge sensor_clk) begin
        if (sensor_rst) begin
            in_vld_q  <= 1'b0;
            mclr_q    <= 1'b0;
            chg_q     <= 1'b0;
            in_ch_q   <= '0;
            in_data_q <= '0;
            dec_q     <= '0;
        end else begin
            in_vld_q <= accept;
            mclr_q   <= mask_drop;
            chg_q    <= (dec_in != dec_q);
            dec_q    <= dec_in;
            if (accept || mask_drop) begin
                in_ch_q   <= adc_channel_in;
                in_data_q <= adc_data_in;
            end
        end
    end

    logic signed [AW-1:0] acc_q [NUM_CH];
    logic [CW-1:0]        cnt_q [NUM_CH];
    logic signed [AW-1:0] acc_sel;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] acc_shr;
    logic [CW-1:0]        cnt_sel;
    logic [CW-1:0]        win_last;
    logic                 win_done;

    always_comb begin
        acc_sel  = chg_q ? '0 : acc_q[in_ch_q];
        cnt_sel  = chg_q ? '0 : cnt_q[in_ch_q];
        acc_next = acc_sel
                 + {{MAX_DECIM_LOG2{in_data_q[DATA_WIDTH-1]}}, in_data_q};
        win_last = CW'((32'd1 << dec_q) - 32'd1);
        win_done = (cnt_sel == win_last);
        acc_shr  = acc_next >>> dec_q;
    end

    always_ff @(posedge sensor_clk) begin
        if (sensor_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_vld_q && in_ch_q == CH_ID_WIDTH'(i)) begin
                    acc_q[i] <= win_done ? '0 : acc_next;
                    cnt_q[i] <= win_done ? '0 : cnt_sel + CW'(1);
                end else if (chg_q
                             || (mclr_q && in_ch_q == CH_ID_WIDTH'(i))) begin
                    acc_q[i] <= '0;
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    logic        s1_vld;
    acq_sample_t s1_q;

    always_ff @(posedge sensor_clk) begin
        if (sensor_rst) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else begin
            s1_vld <= in_vld_q && win_done;
            if (in_vld_q && win_done) begin
                s1_q.channel <= in_ch_q;
                s1_q.data    <= acc_shr[DATA_WIDTH-1:0];
            end
        end
    end

    acq_sample_t fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        ovf_evt;

    acq_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sensor_clk),
        .rst   (sensor_rst),
        .push  (s1_vld),
        .din   (s1_q),
        .pop   (out_if.out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign out_if.out_valid   = !fifo_empty;
    assign out_if.out_data    = fifo_dout.data;
    assign out_if.out_channel = fifo_dout.channel;
    assign ovf_evt = s1_vld && fifo_full && !out_if.out_ready;

    always_ff @(posedge sensor_clk) begin
        if (sensor_rst || cfg_clr_stats) begin
            ovf_count   <= '0;
            badch_count <= '0;
        end else begin
            if (ovf_evt) begin
                ovf_count <= sat_inc(ovf_count);
            end
            if (bad_evt) begin
                badch_count <= sat_inc(badch_count);
            end
        end
    end

endmodule

// File: tb/tb_neural_acq_multich_frontend.sv
// Directed plus randomized bench against a window-list reference model.
module tb_neural_acq_multich_frontend;

    localparam int NCH   = 12;
    localparam int DEPTH = 8;
    localparam int SMAX  = 65535;

    logic        sensor_clk = 1'b0;
    logic        sensor_rst;
    logic [15:0] adc_data_in;
    logic [3:0]  adc_channel_in;
    logic        adc_valid_in;
    logic [11:0] ch_enable_mask;
    logic [1:0]  cfg_decim_log2;
    logic        cfg_clr_stats;
    logic [15:0] ovf_count;
    logic [15:0] badch_count;
    logic [3:0]  fifo_level;

    neural_acq_out_if out_if ();

    always #5 sensor_clk = ~sensor_clk;

    neural_acq_multich_frontend #(
        .NUM_CH (NCH)
    ) dut (
        .sensor_clk     (sensor_clk),
        .sensor_rst     (sensor_rst),
        .adc_data_in    (adc_data_in),
        .adc_channel_in (adc_channel_in),
        .adc_valid_in   (adc_valid_in),
        .ch_enable_mask (ch_enable_mask),
        .cfg_decim_log2 (cfg_decim_log2),
        .cfg_clr_stats  (cfg_clr_stats),
        .out_if         (out_if),
        .ovf_count      (ovf_count),
        .badch_count    (badch_count),
        .fifo_level     (fifo_level)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [19:0] mq [$];
    logic        pa_v, pb_v;
    logic [19:0] pa, pb;
    int          wsum [NCH];
    int          wn   [NCH];
    int          last_cfg;
    int          m_ovf, m_bad;

    function automatic int fdiv(input int s, input int w);
        int q;
        q = s / w;
        if ((s % w != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_windows();
        for (int c = 0; c < NCH; c++) begin
            wsum[c] = 0;
            wn[c]   = 0;
        end
    endtask

    // Reference: results appear in the FIFO two edges after their last sample.
    task automatic model_edge();
        logic        nv;
        logic [19:0] nr;
        int          c;
        nv = 1'b0;
        nr = '0;
        if (sensor_rst) begin
            mq.delete();
            pa_v = 1'b0; pb_v = 1'b0;
            clear_windows();
            last_cfg = 0; m_ovf = 0; m_bad = 0;
            return;
        end
        if (mq.size() > 0 && out_if.out_ready) void'(mq.pop_front());
        if (pa_v) begin
            if (mq.size() < DEPTH) mq.push_back(pa);
            else if (m_ovf < SMAX) m_ovf++;
        end
        pa_v = pb_v; pa = pb;
        if (int'(cfg_decim_log2) != last_cfg) begin
            clear_windows();
            last_cfg = int'(cfg_decim_log2);
        end
        if (adc_valid_in) begin
            c = int'(adc_channel_in);
            if (c >= NCH) begin
                if (m_bad < SMAX) m_bad++;
            end else if (!ch_enable_mask[c]) begin
                wsum[c] = 0; wn[c] = 0;
            end else begin
                wsum[c] += int'($signed(adc_data_in));
                wn[c]++;
                if (wn[c] == (1 << last_cfg)) begin
                    nv = 1'b1;
                    nr = {adc_channel_in,
                          16'(fdiv(wsum[c], 1 << last_cfg))};
                    wsum[c] = 0; wn[c] = 0;
                end
            end
        end
        pb_v = nv; pb = nr;
        if (cfg_clr_stats) begin
            m_ovf = 0; m_bad = 0;
        end
    endtask

    task automatic check();
        chk("out_valid", 32'(out_if.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", 32'(out_if.out_data), 32'(mq[0][15:0]));
            chk("out_channel", 32'(out_if.out_channel), 32'(mq[0][19:16]));
        end
        chk("fifo_level", 32'(fifo_level), mq.size());
        chk("ovf_count", 32'(ovf_count), m_ovf);
        chk("badch_count", 32'(badch_count), m_bad);
    endtask

    task automatic cyc();
        @(posedge sensor_clk);
        model_edge();
        #1;
        check();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic smp(input logic [3:0] ch, input logic [15:0] d);
        adc_valid_in   = 1'b1;
        adc_channel_in = ch;
        adc_data_in    = d;
        cyc();
        adc_valid_in = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        sensor_rst       = 1'b1;
        adc_data_in      = '0;
        adc_channel_in   = '0;
        adc_valid_in     = 1'b0;
        ch_enable_mask   = '1;
        cfg_decim_log2   = 2'd0;
        cfg_clr_stats    = 1'b0;
        out_if.out_ready = 1'b1;
        idle(2);
        chk("rst_out_data", 32'(out_if.out_data), 0);
        chk("rst_out_channel", 32'(out_if.out_channel), 0);
        sensor_rst = 1'b0;
        idle(1);

        // bypass latency and ordering
        smp(4'd3, 16'h1234);
        smp(4'd5, 16'hFFFE);
        chk("lat_not_yet", 32'(out_if.out_valid), 0);
        cyc();
        chk("lat_ch3", {out_if.out_channel, out_if.out_data}, {4'd3, 16'h1234});
        cyc();
        chk("lat_ch5", {out_if.out_channel, out_if.out_data}, {4'd5, 16'hFFFE});
        idle(2);

        // window of 4
        cfg_decim_log2 = 2'd2;
        smp(4'd1, 16'd10);
        smp(4'd1, 16'd20);
        smp(4'd1, 16'd30);
        idle(2);
        chk("win4_none", 32'(out_if.out_valid), 0);
        smp(4'd1, 16'hFFFC);
        idle(2);
        chk("win4_avg", {out_if.out_channel, out_if.out_data}, {4'd1, 16'd14});
        idle(2);

        // window of 2 with negative floor, then mid-window cfg change
        cfg_decim_log2 = 2'd1;
        smp(4'd2, 16'hFFFD);
        smp(4'd2, 16'hFFFC);
        idle(2);
        chk("win2_neg", 32'(out_if.out_data), 32'hFFFC);
        idle(2);
        smp(4'd2, 16'd100);
        cfg_decim_log2 = 2'd2;
        smp(4'd2, 16'd1);
        smp(4'd2, 16'd2);
        smp(4'd2, 16'd3);
        smp(4'd2, 16'd4);
        idle(2);
        chk("cfgchg_avg", {out_if.out_channel, out_if.out_data}, {4'd2, 16'd2});
        idle(2);

        // overflow with stalled output, then drain
        cfg_decim_log2   = 2'd0;
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) smp(4'd0, 16'(i));
        idle(2);
        chk("ovf_level", 32'(fifo_level), 8);
        chk("ovf_count4", 32'(ovf_count), 4);
        held = out_if.out_data;
        idle(3);
        chk("stall_stable", 32'(out_if.out_data), 32'(held));
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 32'(out_if.out_data), i);
            cyc();
        end
        idle(1);

        // masked channel and bad tag, then clear colliding with bad tag
        ch_enable_mask = 12'hFEF;
        smp(4'd4, 16'h0042);
        smp(4'd15, 16'h0007);
        idle(3);
        chk("mask_noout", 32'(out_if.out_valid), 0);
        chk("badch1", 32'(badch_count), 1);
        cfg_clr_stats = 1'b1;
        smp(4'd15, 16'h0008);
        cfg_clr_stats = 1'b0;
        chk("clr_wins", 32'(badch_count), 0);
        ch_enable_mask = '1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            adc_valid_in     = ($urandom_range(0, 9) < 7);
            adc_channel_in   = 4'($urandom_range(0, 15));
            adc_data_in      = 16'($urandom);
            out_if.out_ready = ($urandom_range(0, 9) < 6);
            cfg_clr_stats    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0)
                cfg_decim_log2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0)
                ch_enable_mask = 12'($urandom) | 12'h0F0;
            cyc();
        end
        adc_valid_in     = 1'b0;
        cfg_clr_stats    = 1'b0;
        out_if.out_ready = 1'b1;
        ch_enable_mask   = '1;
        idle(12);

        // reset mid-operation
        out_if.out_ready = 1'b0;
        cfg_decim_log2   = 2'd0;
        for (int i = 0; i < 5; i++) smp(4'd6, 16'(100 + i));
        cfg_decim_log2 = 2'd2;
        smp(4'd1, 16'd50);
        smp(4'd1, 16'd60);
        chk("pre_rst_level", 32'(fifo_level), 5);
        sensor_rst = 1'b1;
        cyc();
        sensor_rst = 1'b0;
        chk("rst_valid", 32'(out_if.out_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        out_if.out_ready = 1'b1;
        smp(4'd1, 16'd8);
        smp(4'd1, 16'd9);
        smp(4'd1, 16'd10);
        smp(4'd1, 16'hFFFF);
        idle(2);
        chk("post_rst_avg", {out_if.out_channel, out_if.out_data}, {4'd1, 16'd6});
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
